// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and default widths for the instruction-memory arbiter.
package imem_arb_pkg;

  localparam int unsigned IMEM_ADDR_W = 30;
  localparam int unsigned IMEM_DATA_W = 32;

  typedef enum logic {
    REQ_FETCH  = 1'b0,
    REQ_LOADER = 1'b1
  } req_id_e;

endpackage

// File: rtl/imem_arb_pick.sv
// imem_arb_pick: combinational winner selection between fetch and loader.
// Build option IMEM_ARB_RR_EN: round-robin using the last-grant pointer.
// Without it, the loader wins contention until the hold counter reaches
// MAX_HOLD, at which point fetch gets the next contended slot.
module imem_arb_pick
  import imem_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HC_W     = 3
) (
  input  logic            f_req,
  input  logic            l_req,
  input  logic [HC_W-1:0] hold_cnt,
  input  req_id_e         last,
  output logic            win_valid,
  output req_id_e         win_id
);

`ifdef IMEM_ARB_RR_EN
  // Hold counter has no role in round-robin mode.
  logic unused_cfg;
  assign unused_cfg = ^hold_cnt;
`else
  // Last-grant pointer has no role in fixed-priority mode.
  logic unused_cfg;
  assign unused_cfg = last;
`endif

  // Pick the winner: a lone requester always wins; contention uses the mode policy.
  always_comb begin
    win_valid = f_req | l_req;
    win_id    = REQ_LOADER;
    if (f_req && !l_req) begin
      win_id = REQ_FETCH;
    end else if (f_req && l_req) begin
`ifdef IMEM_ARB_RR_EN
      win_id = (last == REQ_FETCH) ? REQ_LOADER : REQ_FETCH;
`else
      win_id = (hold_cnt == HC_W'(MAX_HOLD)) ? REQ_FETCH : REQ_LOADER;
`endif
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction memory between the core
// fetch port and the loader/debug port. Grants are combinational; read data
// (1-cycle memory latency) is routed back to whoever owned the read.
// Build option IMEM_ARB_RR_EN selects round-robin instead of loader priority
// with the MAX_HOLD starvation guard.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned DATA_W   = IMEM_DATA_W,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  input  logic              l_req_i,
  input  logic              l_we_i,
  input  logic [ADDR_W-1:0] l_addr_i,
  input  logic [DATA_W-1:0] l_wdata_i,
  output logic              l_gnt_o,
  output logic              l_rvalid_o,
  output logic [DATA_W-1:0] l_rdata_o,
  output logic              mem_read_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned HC_W = $clog2(MAX_HOLD + 1);

  logic            win_valid;
  req_id_e         win_id;
  logic            f_gnt;
  logic            l_gnt;
  logic            l_rd_gnt;
  logic            rd_gnt;
  logic            pend_reg;
  req_id_e         owner_reg;
  logic [HC_W-1:0] arb_hold_cnt;
  req_id_e         arb_last;

  imem_arb_pick #(
    .MAX_HOLD (MAX_HOLD),
    .HC_W     (HC_W)
  ) u_pick (
    .f_req     (f_req_i),
    .l_req     (l_req_i),
    .hold_cnt  (arb_hold_cnt),
    .last      (arb_last),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  // Nothing is granted while reset is held low.
  assign f_gnt    = rstn_i && win_valid && (win_id == REQ_FETCH);
  assign l_gnt    = rstn_i && win_valid && (win_id == REQ_LOADER);
  assign l_rd_gnt = l_gnt && !l_we_i;
  assign rd_gnt   = f_gnt || l_rd_gnt;

  assign f_gnt_o = f_gnt;
  assign l_gnt_o = l_gnt;

  // Memory command comes from the winner only; idle address/data are zero.
  assign mem_read_o  = rd_gnt;
  assign mem_raddr_o = f_gnt ? f_addr_i : (l_rd_gnt ? l_addr_i : '0);
  assign mem_write_o = l_gnt && l_we_i;
  assign mem_waddr_o = mem_write_o ? l_addr_i : '0;
  assign mem_wdata_o = mem_write_o ? l_wdata_i : '0;

  // Response routing; also masked during reset so a dropped read never shows.
  assign f_rvalid_o = rstn_i && pend_reg && (owner_reg == REQ_FETCH);
  assign l_rvalid_o = rstn_i && pend_reg && (owner_reg == REQ_LOADER);
  assign f_rdata_o  = f_rvalid_o ? mem_rdata_i : '0;
  assign l_rdata_o  = l_rvalid_o ? mem_rdata_i : '0;

  // Track which requester owns the read returning next cycle.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pend_reg  <= 1'b0;
      owner_reg <= REQ_FETCH;
    end else begin
      pend_reg <= rd_gnt;
      if (rd_gnt) begin
        owner_reg <= f_gnt ? REQ_FETCH : REQ_LOADER;
      end
    end
  end

`ifdef IMEM_ARB_RR_EN
  req_id_e last_reg;

  assign arb_hold_cnt = '0;
  assign arb_last     = last_reg;

  // Remember the most recent grant so contention alternates.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      last_reg <= REQ_FETCH;
    end else if (f_gnt) begin
      last_reg <= REQ_FETCH;
    end else if (l_gnt) begin
      last_reg <= REQ_LOADER;
    end
  end
`else
  logic [HC_W-1:0] hold_cnt_reg;
  logic [HC_W-1:0] hold_cnt_next;

  assign arb_hold_cnt = hold_cnt_reg;
  assign arb_last     = REQ_FETCH;

  // Count loader grants that kept a waiting fetch out; any fetch grant or idle fetch clears it.
  always_comb begin
    hold_cnt_next = hold_cnt_reg;
    if (!f_req_i || f_gnt) begin
      hold_cnt_next = '0;
    end else if (l_gnt) begin
      hold_cnt_next = hold_cnt_reg + 1'b1;
    end
  end

  // Starvation-guard counter register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      hold_cnt_reg <= '0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed self-checking bench for imem_arbiter with a
// behavioural 1-cycle-latency memory. Expected contention order follows
// IMEM_ARB_RR_EN when that macro is defined for the build.
module tb_imem_arbiter;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              f_req_i;
  logic [ADDR_W-1:0] f_addr_i;
  logic              f_gnt_o;
  logic              f_rvalid_o;
  logic [DATA_W-1:0] f_rdata_o;
  logic              l_req_i;
  logic              l_we_i;
  logic [ADDR_W-1:0] l_addr_i;
  logic [DATA_W-1:0] l_wdata_i;
  logic              l_gnt_o;
  logic              l_rvalid_o;
  logic [DATA_W-1:0] l_rdata_o;
  logic              mem_read_o;
  logic [ADDR_W-1:0] mem_raddr_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_waddr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;

  logic [DATA_W-1:0] mem [0:63];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_i = ~clk_i;

  imem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_HOLD (4)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .f_req_i     (f_req_i),
    .f_addr_i    (f_addr_i),
    .f_gnt_o     (f_gnt_o),
    .f_rvalid_o  (f_rvalid_o),
    .f_rdata_o   (f_rdata_o),
    .l_req_i     (l_req_i),
    .l_we_i      (l_we_i),
    .l_addr_i    (l_addr_i),
    .l_wdata_i   (l_wdata_i),
    .l_gnt_o     (l_gnt_o),
    .l_rvalid_o  (l_rvalid_o),
    .l_rdata_o   (l_rdata_o),
    .mem_read_o  (mem_read_o),
    .mem_raddr_o (mem_raddr_o),
    .mem_write_o (mem_write_o),
    .mem_waddr_o (mem_waddr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Single-port memory model: write and registered read on the clock edge.
  always @(posedge clk_i) begin
    if (mem_write_o) mem[mem_waddr_o[5:0]] <= mem_wdata_o;
    if (mem_read_o)  mem_rdata_i <= mem[mem_raddr_o[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Move to the falling edge, where outputs are sampled.
  task automatic sample();
    @(negedge clk_i);
  endtask

`ifdef IMEM_ARB_RR_EN
  bit exp_l [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
  bit exp_l [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'hA0;
    mem[1] = 32'hA1;
    mem[2] = 32'hA2;
    mem[7] = 32'h77;

    rstn_i    = 1'b0;
    f_req_i   = 1'b1;
    f_addr_i  = 30'd3;
    l_req_i   = 1'b1;
    l_we_i    = 1'b0;
    l_addr_i  = 30'd7;
    l_wdata_i = 32'h0;

    // Reset held two cycles with both requesting.
    for (int c = 0; c < 2; c++) begin
      sample();
      check("rst_f_gnt", 32'(f_gnt_o), 32'h0);
      check("rst_l_gnt", 32'(l_gnt_o), 32'h0);
      check("rst_mem_read", 32'(mem_read_o), 32'h0);
      check("rst_mem_write", 32'(mem_write_o), 32'h0);
      check("rst_raddr", 32'(mem_raddr_o), 32'h0);
      check("rst_rvalid", 32'({f_rvalid_o, l_rvalid_o}), 32'h0);
      next_cycle();
    end

    // Release: loader wins first contended cycle.
    rstn_i = 1'b1;
    sample();
    check("rel_l_gnt", 32'(l_gnt_o), 32'h1);
    check("rel_f_gnt", 32'(f_gnt_o), 32'h0);
    check("rel_raddr", 32'(mem_raddr_o), 32'h7);
    next_cycle();
    f_req_i = 1'b0;
    l_req_i = 1'b0;
    sample();
    check("rel_l_rvalid", 32'(l_rvalid_o), 32'h1);
    check("rel_l_rdata", l_rdata_o, 32'h77);
    check("rel_f_rvalid", 32'(f_rvalid_o), 32'h0);
    next_cycle();

    // Fetch-only burst of three reads.
    for (int a = 0; a < 4; a++) begin
      f_req_i  = (a < 3);
      f_addr_i = 30'(a < 3 ? a : 0);
      sample();
      if (a < 3) begin
        check($sformatf("fetch%0d_gnt", a), 32'(f_gnt_o), 32'h1);
        check($sformatf("fetch%0d_raddr", a), 32'(mem_raddr_o), 32'(a));
      end
      if (a > 0) begin
        check($sformatf("fetch%0d_rvalid", a - 1), 32'(f_rvalid_o), 32'h1);
        check($sformatf("fetch%0d_rdata", a - 1), f_rdata_o, 32'hA0 + 32'(a - 1));
      end
      check($sformatf("fetch%0d_l_rvalid", a), 32'(l_rvalid_o), 32'h0);
      next_cycle();
    end
    sample();
    check("fetch_idle_rvalid", 32'(f_rvalid_o), 32'h0);
    next_cycle();

    // Loader write, then fetch reads the written word.
    l_req_i   = 1'b1;
    l_we_i    = 1'b1;
    l_addr_i  = 30'd5;
    l_wdata_i = 32'hDEADBEEF;
    sample();
    check("wr_l_gnt", 32'(l_gnt_o), 32'h1);
    check("wr_mem_write", 32'(mem_write_o), 32'h1);
    check("wr_waddr", 32'(mem_waddr_o), 32'h5);
    check("wr_wdata", mem_wdata_o, 32'hDEADBEEF);
    check("wr_mem_read", 32'(mem_read_o), 32'h0);
    next_cycle();
    l_req_i   = 1'b0;
    l_we_i    = 1'b0;
    l_wdata_i = 32'h0;
    f_req_i   = 1'b1;
    f_addr_i  = 30'd5;
    sample();
    check("wr_no_l_rvalid", 32'(l_rvalid_o), 32'h0);
    check("wr_mem_write_off", 32'(mem_write_o), 32'h0);
    check("rb_f_gnt", 32'(f_gnt_o), 32'h1);
    next_cycle();
    f_req_i = 1'b0;
    sample();
    check("rb_f_rvalid", 32'(f_rvalid_o), 32'h1);
    check("rb_f_rdata", f_rdata_o, 32'hDEADBEEF);
    next_cycle();

    // Continuous contention: fetch reads word 1, loader reads word 2.
    f_req_i  = 1'b1;
    f_addr_i = 30'd1;
    l_req_i  = 1'b1;
    l_we_i   = 1'b0;
    l_addr_i = 30'd2;
    for (int k = 0; k < 11; k++) begin
      if (k == 10) begin
        f_req_i = 1'b0;
        l_req_i = 1'b0;
      end
      sample();
      if (k < 10) begin
        check($sformatf("arb%0d_l_gnt", k), 32'(l_gnt_o), 32'(exp_l[k]));
        check($sformatf("arb%0d_f_gnt", k), 32'(f_gnt_o), 32'(!exp_l[k]));
      end
      if (k > 0) begin
        check($sformatf("arb%0d_l_rdata", k - 1), l_rdata_o, exp_l[k-1] ? 32'hA2 : 32'h0);
        check($sformatf("arb%0d_f_rdata", k - 1), f_rdata_o, exp_l[k-1] ? 32'h0 : 32'hA1);
        check($sformatf("arb%0d_rvalid", k - 1), 32'({f_rvalid_o, l_rvalid_o}),
              exp_l[k-1] ? 32'h1 : 32'h2);
      end
      next_cycle();
    end

    // Reset the cycle after a granted fetch read: response is dropped.
    f_req_i  = 1'b1;
    f_addr_i = 30'd0;
    sample();
    check("rr_f_gnt", 32'(f_gnt_o), 32'h1);
    next_cycle();
    rstn_i  = 1'b0;
    f_req_i = 1'b0;
    sample();
    check("rr_rst_f_rvalid", 32'(f_rvalid_o), 32'h0);
    check("rr_rst_f_rdata", f_rdata_o, 32'h0);
    next_cycle();
    rstn_i = 1'b1;
    sample();
    check("rr_post_f_rvalid", 32'(f_rvalid_o), 32'h0);
    check("rr_post_l_rvalid", 32'(l_rvalid_o), 32'h0);
    check("rr_post_mem_read", 32'(mem_read_o), 32'h0);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
